// File: rtl/pkt_mem_pkg.sv
// Shared types and width helpers for the packet RAM ingress writer.
// Descriptor layout is {addr, len}: address in the upper bits, length in the lower bits.
package pkt_mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StDrop
    } wr_state_e;

    // Byte address width for a RAM of the given depth (depth need not be a power of two).
    function automatic int unsigned addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Length/count width: must hold the value depth itself.
    function automatic int unsigned len_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned desc_w(input int unsigned depth);
        return addr_w(depth) + len_w(depth);
    endfunction

endpackage

// File: rtl/pkt_mem_writer_if.sv
// Bus bundle for pkt_mem_writer: ingress stream, RAM write port, descriptor
// queue, release path and status. Stats outputs exist only with PKT_MEM_WR_STATS_EN.
interface pkt_mem_writer_if
    import pkt_mem_pkg::*;
#(
    parameter int unsigned pBITS  = 8,
    parameter int unsigned pDEPTH = 3072
);
    localparam int unsigned AW = addr_w(pDEPTH);
    localparam int unsigned LW = len_w(pDEPTH);

    logic             ivalid;
    logic             isop;
    logic             ieop;
    logic [pBITS-1:0] idata;
    logic             owr_en;
    logic [AW-1:0]    ow_addr;
    logic [pBITS-1:0] ow_data;
    logic             odesc_valid;
    logic [AW-1:0]    odesc_addr;
    logic [LW-1:0]    odesc_len;
    logic             idesc_ready;
    logic             irelease;
    logic [LW-1:0]    irelease_len;
    logic [LW-1:0]    ofree_cnt;
    logic             odrop;
`ifdef PKT_MEM_WR_STATS_EN
    logic [15:0]      ocnt_pkt_ok;
    logic [15:0]      ocnt_pkt_drop;
`endif

    // Writer side.
    modport slave (
        input  ivalid, isop, ieop, idata, idesc_ready, irelease, irelease_len,
        output owr_en, ow_addr, ow_data, odesc_valid, odesc_addr, odesc_len,
        output ofree_cnt, odrop
`ifdef PKT_MEM_WR_STATS_EN
        , output ocnt_pkt_ok, ocnt_pkt_drop
`endif
    );

    // Environment side: stream source, RAM, arbiter.
    modport master (
        output ivalid, isop, ieop, idata, idesc_ready, irelease, irelease_len,
        input  owr_en, ow_addr, ow_data, odesc_valid, odesc_addr, odesc_len,
        input  ofree_cnt, odrop
`ifdef PKT_MEM_WR_STATS_EN
        , input ocnt_pkt_ok, ocnt_pkt_drop
`endif
    );

endinterface

// File: rtl/pkt_desc_fifo.sv
// Synchronous show-ahead FIFO for packet descriptors. Depth must be a power of two
// (>= 2) so the pointers wrap naturally. A push while full is accepted only if the
// head is popped in the same cycle.
module pkt_desc_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    output logic             full_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] rdata_o
);
    localparam int unsigned PW = $clog2(Depth);
    localparam int unsigned CW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop, push_ok;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == CW'(Depth));
    assign rdata_o = mem_q[rd_ptr_q];
    assign pop     = valid_o && ready_i;
    assign push_ok = push_i && (!full_o || pop);

    // Pointer, occupancy and storage next-state.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/pkt_mem_writer.sv
// Ingress writer for the packet byte RAM: stores sop/eop framed packets in a circular
// buffer, tracks committed free space and queues a {start, length} descriptor per packet.
// Define PKT_MEM_WR_STATS_EN to add saturating committed/dropped packet counters.
module pkt_mem_writer
    import pkt_mem_pkg::*;
#(
    parameter int unsigned pBITS       = 8,
    parameter int unsigned pDEPTH      = 3072,
    parameter int unsigned pDESC_DEPTH = 4
) (
    input logic              iclk,
    input logic              irst,
    pkt_mem_writer_if.slave  bus
);
    localparam int unsigned AW = addr_w(pDEPTH);
    localparam int unsigned LW = len_w(pDEPTH);
    localparam int unsigned DW = desc_w(pDEPTH);
    localparam logic [AW-1:0] LastAddr = AW'(pDEPTH - 1);
    localparam logic [LW-1:0] DepthLen = LW'(pDEPTH);

    wr_state_e        state_q, state_d;
    logic [AW-1:0]    wptr_q, wptr_d, start_ptr_q, start_ptr_d, w_addr_q, w_addr_d;
    logic [LW-1:0]    cur_len_q, cur_len_d, free_q, free_d;
    logic [pBITS-1:0] w_data_q, w_data_d;
    logic             wr_en_q, wr_en_d, drop_q, drop_d;
    logic             push, start_pkt, fifo_full;
    logic [LW-1:0]    push_len;
    logic [LW:0]      free_sum;
    logic [DW-1:0]    fifo_dout;

    // Explicit wrap: pDEPTH is not necessarily a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LastAddr) ? '0 : p + 1'b1;
    endfunction

    // Framing FSM, RAM write port and free-space next-state.
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        start_ptr_d = start_ptr_q;
        cur_len_d   = cur_len_q;
        wr_en_d     = 1'b0;
        w_addr_d    = w_addr_q;
        w_data_d    = w_data_q;
        drop_d      = 1'b0;
        push        = 1'b0;
        push_len    = '0;
        start_pkt   = 1'b0;

        if (bus.ivalid) begin
            case (state_q)
                StIdle: begin
                    if (bus.isop) begin
                        // No descriptor slot or no byte of space: refuse the whole packet.
                        if (fifo_full || free_q == '0) begin
                            drop_d  = 1'b1;
                            state_d = bus.ieop ? StIdle : StDrop;
                        end else begin
                            start_pkt = 1'b1;
                        end
                    end
                end
                StWrite: begin
                    if (bus.isop) begin
                        // Missing eop: abandon the partial packet and restart in place.
                        drop_d    = 1'b1;
                        start_pkt = 1'b1;
                    end else if (cur_len_q == free_q) begin
                        drop_d    = 1'b1;
                        wptr_d    = start_ptr_q;
                        cur_len_d = '0;
                        state_d   = bus.ieop ? StIdle : StDrop;
                    end else begin
                        wr_en_d  = 1'b1;
                        w_addr_d = wptr_q;
                        w_data_d = bus.idata;
                        wptr_d   = ptr_inc(wptr_q);
                        if (bus.ieop) begin
                            push        = 1'b1;
                            push_len    = cur_len_q + 1'b1;
                            start_ptr_d = ptr_inc(wptr_q);
                            cur_len_d   = '0;
                            state_d     = StIdle;
                        end else begin
                            cur_len_d = cur_len_q + 1'b1;
                        end
                    end
                end
                StDrop: begin
                    if (bus.ieop) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // First byte of a packet always lands at start_ptr (wptr is rewound on abort).
        if (start_pkt) begin
            wr_en_d  = 1'b1;
            w_addr_d = start_ptr_q;
            w_data_d = bus.idata;
            wptr_d   = ptr_inc(start_ptr_q);
            if (bus.ieop) begin
                push        = 1'b1;
                push_len    = LW'(1);
                start_ptr_d = ptr_inc(start_ptr_q);
                cur_len_d   = '0;
                state_d     = StIdle;
            end else begin
                cur_len_d = LW'(1);
                state_d   = StWrite;
            end
        end

        // Commit never exceeds free_q, so adding the release first avoids underflow.
        free_sum = {1'b0, free_q} + (bus.irelease ? {1'b0, bus.irelease_len} : '0)
                   - {1'b0, push_len};
        free_d   = (free_sum > {1'b0, DepthLen}) ? DepthLen : free_sum[LW-1:0];
    end

    // Registered state and outputs with synchronous reset.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q     <= StIdle;
            wptr_q      <= '0;
            start_ptr_q <= '0;
            cur_len_q   <= '0;
            free_q      <= DepthLen;
            wr_en_q     <= 1'b0;
            w_addr_q    <= '0;
            w_data_q    <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            start_ptr_q <= start_ptr_d;
            cur_len_q   <= cur_len_d;
            free_q      <= free_d;
            wr_en_q     <= wr_en_d;
            w_addr_q    <= w_addr_d;
            w_data_q    <= w_data_d;
            drop_q      <= drop_d;
        end
    end

    pkt_desc_fifo #(
        .Width (DW),
        .Depth (pDESC_DEPTH)
    ) u_desc_fifo (
        .clk_i   (iclk),
        .rst_i   (irst),
        .push_i  (push),
        .wdata_i ({start_ptr_q, push_len}),
        .full_o  (fifo_full),
        .valid_o (bus.odesc_valid),
        .ready_i (bus.idesc_ready),
        .rdata_o (fifo_dout)
    );

    assign bus.odesc_addr = fifo_dout[DW-1:LW];
    assign bus.odesc_len  = fifo_dout[LW-1:0];
    assign bus.owr_en     = wr_en_q;
    assign bus.ow_addr    = w_addr_q;
    assign bus.ow_data    = w_data_q;
    assign bus.ofree_cnt  = free_q;
    assign bus.odrop      = drop_q;

`ifdef PKT_MEM_WR_STATS_EN
    logic [15:0] cnt_ok_q, cnt_ok_d, cnt_drop_q, cnt_drop_d;

    // Saturating packet counters, stepped with the descriptor push / drop pulse.
    always_comb begin
        cnt_ok_d   = cnt_ok_q;
        cnt_drop_d = cnt_drop_q;
        if (push && cnt_ok_q != 16'hFFFF) begin
            cnt_ok_d = cnt_ok_q + 16'd1;
        end
        if (drop_d && cnt_drop_q != 16'hFFFF) begin
            cnt_drop_d = cnt_drop_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge iclk) begin
        if (irst) begin
            cnt_ok_q   <= '0;
            cnt_drop_q <= '0;
        end else begin
            cnt_ok_q   <= cnt_ok_d;
            cnt_drop_q <= cnt_drop_d;
        end
    end

    assign bus.ocnt_pkt_ok   = cnt_ok_q;
    assign bus.ocnt_pkt_drop = cnt_drop_q;
`endif

endmodule

// File: tb/tb_pkt_mem_writer.sv
// Scoreboard bench for pkt_mem_writer (pDEPTH=16, pDESC_DEPTH=4).
module tb_pkt_mem_writer;
    localparam int unsigned Depth = 16;

    typedef struct packed {logic [3:0] addr; logic [7:0] data;} wr_t;
    typedef struct packed {logic [3:0] addr; logic [4:0] len;} desc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pkt_mem_writer_if #(.pBITS(8), .pDEPTH(Depth)) bus ();

    pkt_mem_writer #(
        .pBITS       (8),
        .pDEPTH      (Depth),
        .pDESC_DEPTH (4)
    ) dut (
        .iclk (clk),
        .irst (rst),
        .bus  (bus)
    );

    wr_t   exp_wr[$];
    desc_t exp_desc[$];
    int    exp_drops = 0;
    int    errors    = 0;
    int    checks    = 0;
    wr_t   mon_wr;
    desc_t mon_desc;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a write, descriptor or drop.
    always @(negedge clk) begin
        if (bus.owr_en === 1'b1) begin
            check("write_expected", exp_wr.size() > 0, 1);
            if (exp_wr.size() > 0) begin
                mon_wr = exp_wr.pop_front();
                check("wr_addr", bus.ow_addr, mon_wr.addr);
                check("wr_data", bus.ow_data, mon_wr.data);
            end
        end
        if (bus.odesc_valid === 1'b1 && bus.idesc_ready === 1'b1) begin
            check("desc_expected", exp_desc.size() > 0, 1);
            if (exp_desc.size() > 0) begin
                mon_desc = exp_desc.pop_front();
                check("desc_addr", bus.odesc_addr, mon_desc.addr);
                check("desc_len", bus.odesc_len, mon_desc.len);
            end
        end
        if (bus.odrop === 1'b1) begin
            check("drop_expected", exp_drops > 0, 1);
            if (exp_drops > 0) exp_drops--;
        end
    end

    task automatic beat(input logic sop, input logic eop, input logic [7:0] d);
        bus.ivalid = 1'b1;
        bus.isop   = sop;
        bus.ieop   = eop;
        bus.idata  = d;
        @(posedge clk);
        #1;
        bus.ivalid = 1'b0;
        bus.isop   = 1'b0;
        bus.ieop   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rel(input int n);
        bus.irelease     = 1'b1;
        bus.irelease_len = 5'(n);
        @(posedge clk);
        #1;
        bus.irelease     = 1'b0;
        bus.irelease_len = '0;
    endtask

    // Complete packet expected to be written and committed.
    task automatic send_pkt(input int start, input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            exp_wr.push_back('{addr: 4'((start + i) % Depth), data: 8'(base + i)});
            if (i == len - 1) exp_desc.push_back('{addr: 4'(start), len: 5'(len)});
            beat(i == 0, i == len - 1, 8'(base + i));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ivalid       = 1'b0;
        bus.isop         = 1'b0;
        bus.ieop         = 1'b0;
        bus.idata        = '0;
        bus.idesc_ready  = 1'b1;
        bus.irelease     = 1'b0;
        bus.irelease_len = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_wr_en", bus.owr_en, 0);
        check("rst_addr", bus.ow_addr, 0);
        check("rst_data", bus.ow_data, 0);
        check("rst_desc_valid", bus.odesc_valid, 0);
        check("rst_drop", bus.odrop, 0);
        check("rst_free", bus.ofree_cnt, 16);

        // 5-byte packet at address 0
        send_pkt(0, 5, 8'hA0);
        check("s1_desc_valid", bus.odesc_valid, 1);
        check("s1_free", bus.ofree_cnt, 11);
        idle(2);
        rel(5);
        check("s1_free_rel", bus.ofree_cnt, 16);

        // Advance start to 14, then a wrapping packet
        send_pkt(5, 9, 8'h10);
        idle(1);
        rel(9);
        send_pkt(14, 4, 8'hB0);
        check("s2_free", bus.ofree_cnt, 12);
        rel(10);
        check("s2_clamp", bus.ofree_cnt, 16);

        // Out of space mid-packet: 3 bytes written, drop on 4th, rewind
        send_pkt(2, 13, 8'h20);
        check("s3_free", bus.ofree_cnt, 3);
        for (int i = 0; i < 6; i++) begin
            if (i < 3) exp_wr.push_back('{addr: 4'((15 + i) % Depth), data: 8'(8'hC0 + i)});
            if (i == 3) exp_drops++;
            beat(i == 0, i == 5, 8'(8'hC0 + i));
            if (i == 3) check("s3_odrop_pulse", bus.odrop, 1);
        end
        send_pkt(15, 2, 8'hD0);
        check("s3_free_after", bus.ofree_cnt, 1);
        idle(2);
        rel(15);

        // Descriptor FIFO full: fifth packet dropped, then drained in order
        idle(2);
        bus.idesc_ready = 1'b0;
        for (int k = 0; k < 4; k++) send_pkt(1 + 2 * k, 2, 8'(8'h40 + 16 * k));
        check("s4_desc_valid", bus.odesc_valid, 1);
        exp_drops++;
        beat(1'b1, 1'b0, 8'hEE);
        check("s4_odrop", bus.odrop, 1);
        beat(1'b0, 1'b1, 8'hEF);
        check("s4_free", bus.ofree_cnt, 8);
        bus.idesc_ready = 1'b1;
        idle(6);
        check("s4_desc_drained", exp_desc.size(), 0);
        rel(8);
        check("s4_free_rel", bus.ofree_cnt, 16);

        // 1-byte packet with release in the commit cycle
        send_pkt(9, 6, 8'h60);
        check("s5_free_pre", bus.ofree_cnt, 10);
        exp_wr.push_back('{addr: 4'd15, data: 8'h77});
        exp_desc.push_back('{addr: 4'd15, len: 5'd1});
        bus.irelease     = 1'b1;
        bus.irelease_len = 5'd5;
        beat(1'b1, 1'b1, 8'h77);
        bus.irelease     = 1'b0;
        bus.irelease_len = '0;
        check("s5_free_net", bus.ofree_cnt, 14);
        idle(2);
        rel(2);

        // sop after 3 bytes: abort and restart at the same start address
        for (int i = 0; i < 3; i++) begin
            exp_wr.push_back('{addr: 4'(i), data: 8'(8'h80 + i)});
            beat(i == 0, 1'b0, 8'(8'h80 + i));
        end
        exp_drops++;
        send_pkt(0, 3, 8'h90);
        check("s6_free", bus.ofree_cnt, 13);
        idle(2);

        // Reset mid-packet: nothing committed, pointers back to 0
        exp_wr.push_back('{addr: 4'd3, data: 8'hE0});
        exp_wr.push_back('{addr: 4'd4, data: 8'hE1});
        beat(1'b1, 1'b0, 8'hE0);
        beat(1'b0, 1'b0, 8'hE1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("s7_free_rst", bus.ofree_cnt, 16);
        check("s7_desc_valid", bus.odesc_valid, 0);
        idle(2);
        send_pkt(0, 1, 8'hF0);
        check("s7_free", bus.ofree_cnt, 15);

        idle(5);
        check("end_wr_queue", exp_wr.size(), 0);
        check("end_desc_queue", exp_desc.size(), 0);
        check("end_drops", exp_drops, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
